// File: rtl/sr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_sched_pkg
// Description : Shared definitions for the SR latch scheduler: op encodings
//               and the scheduler state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package sr_sched_pkg;

    // Per-requester op encoding, two bits per requester on the op bus.
    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT  = 3'd1,
        DRIVE  = 3'd2,
        SETTLE = 3'd3,
        ACK    = 3'd4
    } state_t;

endpackage : sr_sched_pkg
`default_nettype wire

// File: rtl/sr_latch_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches req upward from
//               ptr with wrap-around and returns the first requester found.
// Ports       : req        - request vector
//               ptr        - search start index (0..N_REQ-1)
//               win_onehot - one-hot winner (all zero when no request)
//               win_idx    - binary index of the winner
//               win_valid  - at least one request is pending
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import sr_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [PTR_W-1:0] win_idx,
    output logic             win_valid
);

    // One spare bit so ptr + offset (< 2*N_REQ) cannot overflow before the
    // single wrap subtraction.
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        sum        = '0;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (sum >= (PTR_W + 1)'(N_REQ)) begin
                sum = sum - (PTR_W + 1)'(N_REQ);
            end
            cand = sum[PTR_W-1:0];
            // First hit in search order wins; later candidates are ignored.
            if (!win_valid && req[cand]) begin
                win_valid        = 1'b1;
                win_idx          = cand;
                win_onehot[cand] = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/sr_latch_sched.sv
`default_nettype none
// ============================================================================
// Module      : sr_latch_sched
// Description : Round-robin scheduler sharing one clocked SR latch among
//               N_REQ requesters. Serialises read/set/clear requests, drives
//               a non-overlapping s/r pulse, waits for the latch to settle,
//               samples q and acknowledges the winner.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous active-low reset
//               req   - per-requester request, held until ack
//               op    - per-requester op, bits [2i+1:2i]
//               q     - latch output
//               s, r  - latch set / reset inputs
//               grant - one-hot requester being served
//               ack   - one-cycle acknowledge to the served requester
//               rd_q  - q sampled for the served request
//               busy  - scheduler not in IDLE
//               err   - readback mismatch / illegal op (only when
//                       SR_READBACK_CHECK_EN is defined)
// Options     : `define SR_READBACK_CHECK_EN to add the err output.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_latch_sched
    import sr_sched_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int HOLD_CYCLES   = 1,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] op,
    input  logic               q,
    output logic               s,
    output logic               r,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   ack,
    output logic               rd_q,
    output logic               busy
`ifdef SR_READBACK_CHECK_EN
    ,
    output logic               err
`endif
);

    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counters run down to zero, so they load with length-1 on state entry.
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(N_REQ - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win_idx;
    logic [1:0]         op_lat;

    logic [N_REQ-1:0]   arb_onehot;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [1:0]         op_sel;
    logic               s_nxt;
    logic               r_nxt;
    logic               sample;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req        (req),
        .ptr        (ptr),
        .win_onehot (arb_onehot),
        .win_idx    (arb_idx),
        .win_valid  (arb_valid)
    );

    // Pick the winner's op field using the one-hot vector so no variable
    // part-select is needed.
    always_comb begin
        op_sel = OP_READ;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_onehot[i]) begin
                op_sel = op[2*i +: 2];
            end
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                state_nxt = DRIVE;
                cnt_nxt   = HOLD_LOAD;
            end
            DRIVE: begin
                if (cnt == '0) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = ACK;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // s and r are registered so the latch sees clean, glitch-free pulses.
    // Both decode from the one latched op, so they can never overlap; read
    // and illegal ops leave both low.
    always_comb begin
        s_nxt  = (state_nxt == DRIVE) && (op_lat == OP_SET);
        r_nxt  = (state_nxt == DRIVE) && (op_lat == OP_CLR);
        sample = (state == SETTLE) && (cnt == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            win_idx <= '0;
            op_lat  <= OP_READ;
            s       <= 1'b0;
            r       <= 1'b0;
            grant   <= '0;
            ack     <= '0;
            rd_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            s     <= s_nxt;
            r     <= r_nxt;
            ack   <= '0;
            case (state)
                IDLE: begin
                    // Winner and op are frozen here; later req/op changes
                    // cannot disturb the transaction in flight.
                    if (arb_valid) begin
                        grant   <= arb_onehot;
                        win_idx <= arb_idx;
                        op_lat  <= op_sel;
                    end
                end
                ACK: begin
                    grant <= '0;
                    ptr   <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                end
                default: begin
                end
            endcase
            if (sample) begin
                rd_q <= q;
                ack  <= grant;
            end
        end
    end

`ifdef SR_READBACK_CHECK_EN
    // Flags a latch that did not follow the commanded op, and any illegal
    // op (which was executed as a plain read). Aligned with ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else begin
            err <= sample && (((op_lat == OP_SET) && !q) ||
                              ((op_lat == OP_CLR) &&  q) ||
                               (op_lat == OP_ILL));
        end
    end
`endif

    assign busy = (state != IDLE);

endmodule : sr_latch_sched
`default_nettype wire

// File: tb/tb_sr_latch_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sr_latch_sched
// Description : Scoreboard bench for sr_latch_sched. Two instances: default
//               parameters, and HOLD_CYCLES=3 / SETTLE_CYCLES=2. A behavioural
//               clocked SR latch feeds q back to each instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_latch_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       force_q0;
    logic [3:0] req,  req2;
    logic [7:0] op,   op2;
    logic       q,    q2;
    logic       s,    s2;
    logic       r,    r2;
    logic [3:0] grant, grant2;
    logic [3:0] ack,   ack2;
    logic       rd_q,  rd_q2;
    logic       busy,  busy2;
`ifdef SR_READBACK_CHECK_EN
    logic       err,   err2;
`endif

    sr_latch_sched #(.N_REQ(4), .HOLD_CYCLES(1), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .q(q),
        .s(s), .r(r), .grant(grant), .ack(ack), .rd_q(rd_q), .busy(busy)
`ifdef SR_READBACK_CHECK_EN
        , .err(err)
`endif
    );

    sr_latch_sched #(.N_REQ(4), .HOLD_CYCLES(3), .SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .op(op2), .q(q2),
        .s(s2), .r(r2), .grant(grant2), .ack(ack2), .rd_q(rd_q2), .busy(busy2)
`ifdef SR_READBACK_CHECK_EN
        , .err(err2)
`endif
    );

    // Behavioural clocked SR latches; force_q0 models a stuck latch.
    always @(posedge clk or negedge reset) begin
        if (!reset)        q <= 1'b0;
        else if (force_q0) q <= 1'b0;
        else if (s)        q <= 1'b1;
        else if (r)        q <= 1'b0;
    end
    always @(posedge clk or negedge reset) begin
        if (!reset)  q2 <= 1'b0;
        else if (s2) q2 <= 1'b1;
        else if (r2) q2 <= 1'b0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   idx;
        logic rdq;
        logic er;
        int   at;
    } exp_t;

    exp_t sb[$];
    exp_t sb2[$];

    int errors = 0;
    int checks = 0;
    int s_cnt = 0, r_cnt = 0, s2_cnt = 0, r2_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents an ack.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("no_s_and_r", {31'd0, s & r}, 32'd0);
                chk("no_s2_and_r2", {31'd0, s2 & r2}, 32'd0);
            end
            s_cnt  += int'(s);
            r_cnt  += int'(r);
            s2_cnt += int'(s2);
            r2_cnt += int'(r2);
            if (ack != 4'b0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {28'd0, ack}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_onehot", {28'd0, ack}, 32'd1 << e.idx);
                    chk("rd_q", {31'd0, rd_q}, {31'd0, e.rdq});
                    chk("ack_cycle", cyc, e.at);
`ifdef SR_READBACK_CHECK_EN
                    chk("err", {31'd0, err}, {31'd0, e.er});
`endif
                end
            end
            if (ack2 != 4'b0) begin
                if (sb2.size() == 0) begin
                    chk("unexpected_ack2", {28'd0, ack2}, 32'd0);
                end else begin
                    e = sb2.pop_front();
                    chk("ack2_onehot", {28'd0, ack2}, 32'd1 << e.idx);
                    chk("rd_q2", {31'd0, rd_q2}, {31'd0, e.rdq});
                    chk("ack2_cycle", cyc, e.at);
`ifdef SR_READBACK_CHECK_EN
                    chk("err2", {31'd0, err2}, {31'd0, e.er});
`endif
                end
            end
        end
    end

    // Bounded wait for an ack on instance 0 or 1, starting at this negedge.
    task automatic wait_ack(input int which);
        for (int k = 0; k < 40; k++) begin
            if (which == 0 && ack  != 4'b0) return;
            if (which == 1 && ack2 != 4'b0) return;
            @(negedge clk);
        end
        chk("ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin : stim
        int s0, r0, base;
        reset = 1'b0; force_q0 = 1'b0;
        req = '0; op = '0; req2 = '0; op2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_s",     {31'd0, s},     32'd0);
        chk("rst_r",     {31'd0, r},     32'd0);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_ack",   {28'd0, ack},   32'd0);
        chk("rst_rd_q",  {31'd0, rd_q},  32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_busy2", {31'd0, busy2}, 32'd0);
`ifdef SR_READBACK_CHECK_EN
        chk("rst_err",   {31'd0, err},   32'd0);
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single set on requester 0, latch starts cleared.
        s0 = s_cnt; r0 = r_cnt;
        op = 8'b00_00_00_01; req = 4'b0001;
        sb.push_back('{0, 1'b1, 1'b0, cyc + 4});
        @(negedge clk);
        chk("set_grant", {28'd0, grant}, 32'h1);
        chk("set_busy",  {31'd0, busy},  32'd1);
        wait_ack(0);
        req = '0;
        chk("set_s_cycles", s_cnt - s0, 32'd1);
        chk("set_r_cycles", r_cnt - r0, 32'd0);
        @(negedge clk);

        // Clear on requester 2.
        s0 = s_cnt; r0 = r_cnt;
        op = 8'b00_10_00_00; req = 4'b0100;
        sb.push_back('{2, 1'b0, 1'b0, cyc + 4});
        @(negedge clk);
        chk("clr_grant", {28'd0, grant}, 32'h4);
        wait_ack(0);
        req = '0;
        chk("clr_r_cycles", r_cnt - r0, 32'd1);
        chk("clr_s_cycles", s_cnt - s0, 32'd0);
        @(negedge clk);

        // Reset in the middle of a set pulse on requester 3.
        op = 8'b01_00_00_00; req = 4'b1000;
        repeat (2) @(negedge clk);
        chk("mid_s_high",     {31'd0, s},     32'd1);
        chk("mid_grant",      {28'd0, grant}, 32'h8);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_s",     {31'd0, s},     32'd0);
        chk("mid_rst_grant", {28'd0, grant}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy},  32'd0);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Round robin, all requesters held; pointer must restart at 0.
        s0 = s_cnt; r0 = r_cnt;
        op = 8'b10_01_10_01; req = 4'b1111;
        base = cyc;
        sb.push_back('{0, 1'b1, 1'b0, base + 4});
        sb.push_back('{1, 1'b0, 1'b0, base + 9});
        sb.push_back('{2, 1'b1, 1'b0, base + 14});
        sb.push_back('{3, 1'b0, 1'b0, base + 19});
        sb.push_back('{0, 1'b1, 1'b0, base + 24});
        repeat (24) @(negedge clk);
        req = '0;
        chk("rr_s_cycles", s_cnt - s0, 32'd3);
        chk("rr_r_cycles", r_cnt - r0, 32'd2);
        repeat (2) @(negedge clk);

        // Set with latch stuck at 0 on requester 1 (pointer now 1).
        s0 = s_cnt;
        force_q0 = 1'b1;
        op = 8'b00_00_01_00; req = 4'b0010;
        sb.push_back('{1, 1'b0, 1'b1, cyc + 4});
        @(negedge clk);
        wait_ack(0);
        req = '0; force_q0 = 1'b0;
        chk("stuck_s_cycles", s_cnt - s0, 32'd1);
        @(negedge clk);

        // Illegal op on requester 2 executes as a read of q (0).
        s0 = s_cnt; r0 = r_cnt;
        op = 8'b00_11_00_00; req = 4'b0100;
        sb.push_back('{2, 1'b0, 1'b1, cyc + 4});
        @(negedge clk);
        wait_ack(0);
        req = '0;
        chk("ill_s_cycles", s_cnt - s0, 32'd0);
        chk("ill_r_cycles", r_cnt - r0, 32'd0);
        @(negedge clk);

        // Long hold/settle instance: set, then read back.
        s0 = s2_cnt; r0 = r2_cnt;
        op2 = 8'b00_00_00_01; req2 = 4'b0001;
        sb2.push_back('{0, 1'b1, 1'b0, cyc + 7});
        @(negedge clk);
        wait_ack(1);
        req2 = '0;
        chk("p_set_s_cycles", s2_cnt - s0, 32'd3);
        chk("p_set_r_cycles", r2_cnt - r0, 32'd0);
        @(negedge clk);
        s0 = s2_cnt; r0 = r2_cnt;
        op2 = 8'b00_00_00_00; req2 = 4'b0010;
        sb2.push_back('{1, 1'b1, 1'b0, cyc + 7});
        @(negedge clk);
        chk("p_rd_grant", {28'd0, grant2}, 32'h2);
        wait_ack(1);
        req2 = '0;
        chk("p_rd_s_cycles", s2_cnt - s0, 32'd0);
        chk("p_rd_r_cycles", r2_cnt - r0, 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size() + sb2.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_sr_latch_sched
`default_nettype wire
